// File: rtl/charge_entry_ctrl_if.sv
// Bundles the key-event inputs, the billing back-end handshake and the
// entry status outputs of the recharge entry controller.
interface charge_entry_if #(
    parameter int PHONE_LEN = 11
);
    logic                   digit_stb;
    logic [3:0]             digit;
    logic                   start_stb;
    logic                   clear_stb;
    logic                   enter_stb;
    // charge_req is a level raised on entry to REQ and held until the cycle
    // charge_ack is sampled high; ack seen while no request is pending is ignored.
    logic                   charge_ack;
    logic                   charge_req;
    logic [2:0]             state;
    logic [4*PHONE_LEN-1:0] phone_bcd;
    logic [3:0]             phone_cnt;
    logic [9:0]             amount;
    logic [1:0]             amt_cnt;
    logic                   done;
    logic                   err;
    logic                   timeout;

    modport master (
        output digit_stb, digit, start_stb, clear_stb, enter_stb, charge_ack,
        input  state, phone_bcd, phone_cnt, amount, amt_cnt,
               charge_req, done, err, timeout
    );

    modport slave (
        input  digit_stb, digit, start_stb, clear_stb, enter_stb, charge_ack,
        output state, phone_bcd, phone_cnt, amount, amt_cnt,
               charge_req, done, err, timeout
    );
endinterface

// File: rtl/charge_entry_ctrl.sv
// Phone-recharge entry sequencer: collects phone number and amount from
// keypad strobes, validates them and raises a charge request to the back end.
module charge_entry_ctrl #(
    parameter int PHONE_LEN  = 11,
    parameter int AMT_DIGITS = 3,
    parameter int MAX_AMT    = 500,
    parameter int TIMEOUT    = 5000000
) (
    input logic           CLK,
    input logic           RST,
    charge_entry_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PHONE  = 3'd1,
        S_AMOUNT = 3'd2,
        S_REQ    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int          PW           = 4 * PHONE_LEN;
    localparam logic [3:0]  PHONE_LEN_C  = 4'(PHONE_LEN);
    localparam logic [1:0]  AMT_DIGITS_C = 2'(AMT_DIGITS);
    localparam logic [9:0]  MAX_AMT_C    = 10'(MAX_AMT);
    localparam logic [23:0] IDLE_LIM_C   = 24'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  phone_q, phone_d;
    logic [3:0]     phone_cnt_q, phone_cnt_d;
    logic [9:0]     amount_q, amount_d;
    logic [1:0]     amt_cnt_q, amt_cnt_d;
    logic [23:0]    idle_q, idle_d;
    logic           charge_req_q, charge_req_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           timeout_q, timeout_d;

    logic           any_stb;
    logic           digit_ok;
    logic [23:0]    idle_inc;

    assign any_stb  = bus.digit_stb | bus.start_stb | bus.clear_stb | bus.enter_stb;
    assign digit_ok = bus.digit_stb && (bus.digit <= 4'd9);
    assign idle_inc = idle_q + 24'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            phone_q      <= '0;
            phone_cnt_q  <= '0;
            amount_q     <= '0;
            amt_cnt_q    <= '0;
            idle_q       <= '0;
            charge_req_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phone_q      <= phone_d;
            phone_cnt_q  <= phone_cnt_d;
            amount_q     <= amount_d;
            amt_cnt_q    <= amt_cnt_d;
            idle_q       <= idle_d;
            charge_req_q <= charge_req_d;
            done_q       <= done_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phone_d      = phone_q;
        phone_cnt_d  = phone_cnt_q;
        amount_d     = amount_q;
        amt_cnt_d    = amt_cnt_q;
        idle_d       = '0;
        charge_req_d = charge_req_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;

        // Idle supervision: any strobe restarts the count and beats a same-cycle expiry.
        if ((state_q == S_PHONE || state_q == S_AMOUNT) && !any_stb) begin
            if (idle_inc == IDLE_LIM_C) begin
                state_d     = S_IDLE;
                timeout_d   = 1'b1;
                phone_d     = '0;
                phone_cnt_d = '0;
                amount_d    = '0;
                amt_cnt_d   = '0;
            end else begin
                idle_d = idle_inc;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start_stb) begin
                    state_d     = S_PHONE;
                    phone_d     = '0;
                    phone_cnt_d = '0;
                    amount_d    = '0;
                    amt_cnt_d   = '0;
                end
            end
            S_PHONE: begin
                if (bus.clear_stb) begin
                    if (phone_cnt_q != 4'd0) begin
                        phone_d     = '0;
                        phone_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.enter_stb) begin
                    if (phone_cnt_q == PHONE_LEN_C) state_d = S_AMOUNT;
                    else                            err_d   = 1'b1;
                end else if (digit_ok && phone_cnt_q < PHONE_LEN_C) begin
                    phone_d     = (phone_q << 4) | PW'(bus.digit);
                    phone_cnt_d = phone_cnt_q + 4'd1;
                end
            end
            S_AMOUNT: begin
                if (bus.clear_stb) begin
                    if (amt_cnt_q != 2'd0) begin
                        amount_d  = '0;
                        amt_cnt_d = '0;
                    end else begin
                        state_d = S_PHONE;
                    end
                end else if (bus.enter_stb) begin
                    if (amount_q != 10'd0 && amount_q <= MAX_AMT_C) begin
                        state_d      = S_REQ;
                        charge_req_d = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        amount_d  = '0;
                        amt_cnt_d = '0;
                    end
                end else if (digit_ok && amt_cnt_q < AMT_DIGITS_C) begin
                    amount_d  = amount_q * 10'd10 + {6'd0, bus.digit};
                    amt_cnt_d = amt_cnt_q + 2'd1;
                end
            end
            S_REQ: begin
                if (bus.charge_ack) begin
                    state_d      = S_DONE;
                    charge_req_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.phone_bcd  = phone_q;
    assign bus.phone_cnt  = phone_cnt_q;
    assign bus.amount     = amount_q;
    assign bus.amt_cnt    = amt_cnt_q;
    assign bus.charge_req = charge_req_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_charge_entry_ctrl.sv
// Bench for charge_entry_ctrl: directed flow steps plus random key traffic,
// every cycle compared against a transaction-level model of the entry rules.
module tb_charge_entry_ctrl;
  localparam int PHONE_LEN  = 11;
  localparam int AMT_DIGITS = 3;
  localparam int MAX_AMT    = 500;
  localparam int TIMEOUT    = 20;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  charge_entry_if #(.PHONE_LEN(PHONE_LEN)) bus ();

  charge_entry_ctrl #(
    .PHONE_LEN(PHONE_LEN), .AMT_DIGITS(AMT_DIGITS),
    .MAX_AMT(MAX_AMT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model of the entry session: digits as a list, amount as an integer
  int ph[$];
  int m_state = 0;
  int m_amt   = 0;
  int m_acnt  = 0;
  int m_idle  = 0;
  bit m_req   = 0;
  bit m_done  = 0;
  bit m_err   = 0;
  bit m_to    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [4*PHONE_LEN-1:0] m_bcd();
    logic [4*PHONE_LEN-1:0] v = '0;
    foreach (ph[i]) v = v * 16 + ph[i];
    return v;
  endfunction

  task automatic m_clear_fields();
    ph.delete();
    m_amt  = 0;
    m_acnt = 0;
  endtask

  task automatic model_edge();
    int  cur = m_state;
    int  d   = int'(bus.digit);
    bit  dok = bus.digit_stb && d <= 9;
    bit  stb = bus.digit_stb || bus.start_stb || bus.clear_stb || bus.enter_stb;
    m_done = 0; m_err = 0; m_to = 0;
    if (RST) begin
      m_state = 0; m_clear_fields(); m_idle = 0; m_req = 0;
      return;
    end
    if (cur == 1 || cur == 2) begin
      if (stb) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT - 1) begin
          m_to = 1; m_state = 0; m_clear_fields(); m_idle = 0;
        end
      end
    end else m_idle = 0;
    case (cur)
      0: if (bus.start_stb) begin m_state = 1; m_clear_fields(); end
      1: begin
        if (bus.clear_stb) begin
          if (ph.size() > 0) ph.delete(); else m_state = 0;
        end else if (bus.enter_stb) begin
          if (ph.size() == PHONE_LEN) m_state = 2; else m_err = 1;
        end else if (dok && ph.size() < PHONE_LEN) ph.push_back(d);
      end
      2: begin
        if (bus.clear_stb) begin
          if (m_acnt > 0) begin m_amt = 0; m_acnt = 0; end else m_state = 1;
        end else if (bus.enter_stb) begin
          if (m_amt >= 1 && m_amt <= MAX_AMT) begin m_state = 3; m_req = 1; end
          else begin m_err = 1; m_amt = 0; m_acnt = 0; end
        end else if (dok && m_acnt < AMT_DIGITS) begin
          m_amt = m_amt * 10 + d; m_acnt++;
        end
      end
      3: if (bus.charge_ack) begin m_req = 0; m_done = 1; m_state = 4; end
      4: m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic check_all();
    chk("state",      64'(bus.state),      64'(m_state));
    chk("phone_bcd",  64'(bus.phone_bcd),  64'(m_bcd()));
    chk("phone_cnt",  64'(bus.phone_cnt),  64'(ph.size()));
    chk("amount",     64'(bus.amount),     64'(m_amt));
    chk("amt_cnt",    64'(bus.amt_cnt),    64'(m_acnt));
    chk("charge_req", 64'(bus.charge_req), 64'(m_req));
    chk("done",       64'(bus.done),       64'(m_done));
    chk("err",        64'(bus.err),        64'(m_err));
    chk("timeout",    64'(bus.timeout),    64'(m_to));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
    bus.digit_stb = 0; bus.start_stb = 0; bus.clear_stb = 0;
    bus.enter_stb = 0; bus.charge_ack = 0;
  endtask

  task automatic press(input int d);
    bus.digit_stb = 1; bus.digit = 4'(d); tick();
  endtask
  task automatic start_k(); bus.start_stb = 1; tick(); endtask
  task automatic clear_k(); bus.clear_stb = 1; tick(); endtask
  task automatic enter_k(); bus.enter_stb = 1; tick(); endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ph_a[11] = '{1, 3, 8, 0, 0, 1, 3, 8, 0, 0, 0};
    int ph_b[11] = '{2, 0, 2, 4, 0, 6, 1, 5, 9, 8, 7};
    int r;
    bus.digit_stb = 0; bus.digit = 0; bus.start_stb = 0; bus.clear_stb = 0;
    bus.enter_stb = 0; bus.charge_ack = 0;

    idle_n(2);
    RST = 0;
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_req",   64'(bus.charge_req), 64'd0);

    // full successful transaction
    start_k();
    foreach (ph_a[i]) press(ph_a[i]);
    enter_k();
    chk("t1_cnt",   64'(bus.phone_cnt), 64'd11);
    chk("t1_bcd",   64'(bus.phone_bcd), 64'h13800138000);
    chk("t1_state", 64'(bus.state), 64'd2);
    press(0); press(5); press(0);
    enter_k();
    chk("t2_amt",   64'(bus.amount), 64'd50);
    chk("t2_state", 64'(bus.state), 64'd3);
    chk("t2_req",   64'(bus.charge_req), 64'd1);
    idle_n(3);
    bus.charge_ack = 1; tick();
    chk("t2_req0",  64'(bus.charge_req), 64'd0);
    chk("t2_done",  64'(bus.done), 64'd1);
    tick();
    chk("t2_done0", 64'(bus.done), 64'd0);
    chk("t2_idle",  64'(bus.state), 64'd0);

    // rejected enters, ignored digits, clears
    start_k();
    for (int i = 0; i < 10; i++) press(ph_b[i]);
    enter_k();
    chk("t3_err",  64'(bus.err), 64'd1);
    chk("t3_cnt",  64'(bus.phone_cnt), 64'd10);
    press(12);
    chk("t3_bad_digit", 64'(bus.phone_cnt), 64'd10);
    press(ph_b[10]);
    press(4);
    chk("t3_full", 64'(bus.phone_cnt), 64'd11);
    enter_k();
    press(9); press(9); press(9);
    enter_k();
    chk("t3_err_amt", 64'(bus.err), 64'd1);
    chk("t3_amt0",    64'(bus.amount), 64'd0);
    chk("t3_acnt0",   64'(bus.amt_cnt), 64'd0);
    press(1); press(2); press(3); press(4);
    chk("t3_amt123",  64'(bus.amount), 64'd123);
    clear_k();
    clear_k();
    chk("t3_back",    64'(bus.state), 64'd1);
    chk("t3_keep",    64'(bus.phone_bcd), 64'h20240615987);
    clear_k();
    clear_k();
    chk("t3_exit",    64'(bus.state), 64'd0);

    // clear wins over a same-cycle digit
    start_k();
    for (int i = 0; i < 5; i++) press(i + 1);
    bus.clear_stb = 1; bus.digit_stb = 1; bus.digit = 4'd7; tick();
    chk("t4_cnt0", 64'(bus.phone_cnt), 64'd0);
    chk("t4_bcd0", 64'(bus.phone_bcd), 64'd0);
    clear_k();
    chk("t4_idle", 64'(bus.state), 64'd0);

    // inactivity timeout in AMOUNT
    start_k();
    foreach (ph_a[i]) press(ph_a[i]);
    enter_k();
    idle_n(18);
    chk("t5_no_to", 64'(bus.timeout), 64'd0);
    press(4);
    idle_n(18);
    chk("t5_still", 64'(bus.state), 64'd2);
    tick();
    chk("t5_to",    64'(bus.timeout), 64'd1);
    chk("t5_state", 64'(bus.state), 64'd0);
    chk("t5_bcd0",  64'(bus.phone_bcd), 64'd0);

    // reset while a request is pending
    start_k();
    foreach (ph_b[i]) press(ph_b[i]);
    enter_k();
    press(2); enter_k();
    chk("t6_req", 64'(bus.charge_req), 64'd1);
    RST = 1; tick();
    RST = 0;
    chk("t6_req0",  64'(bus.charge_req), 64'd0);
    chk("t6_state", 64'(bus.state), 64'd0);
    chk("t6_done0", 64'(bus.done), 64'd0);
    bus.charge_ack = 1; tick();
    chk("t6_ack_ign", 64'(bus.state), 64'd0);

    // random key traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) bus.start_stb = 1;
      else if (r < 62) begin bus.digit_stb = 1; bus.digit = 4'($urandom_range(0, 11)); end
      else if (r < 66) bus.clear_stb = 1;
      else if (r < 74) bus.enter_stb = 1;
      else if (r < 77) begin
        bus.clear_stb = $urandom_range(0, 1) != 0; bus.enter_stb = 1;
        bus.digit_stb = 1; bus.digit = 4'($urandom_range(0, 9));
      end
      bus.charge_ack = $urandom_range(0, 3) == 0;
      if (r >= 77 && r < 80) idle_n(int'($urandom_range(1, 25)));
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/charge_entry_ctrl.md
Name: charge_entry_ctrl

Overview:
- Sequences a phone-recharge transaction from debounced keypad events produced by the key matrix scanner.
- Collects an 11-digit phone number and a recharge amount, validates them, and issues a charge request to the billing/display back end.
- Owns the whole entry flow: start, digit entry, clear/back-out, enter/confirm, and inactivity timeout.

Parameters:
PHONE_LEN, 11, number of phone digits required (1..15)
AMT_DIGITS, 3, maximum amount digits (1..3)
MAX_AMT, 500, largest accepted amount (≤ 999)
TIMEOUT, 5000000, idle cycles in PHONE/AMOUNT before abort (< 2^24)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
digit_stb  in  1  one-cycle strobe, digit key pressed
digit  in  4  key value; values > 9 ignored
start_stb  in  1  one-cycle strobe, start key
clear_stb  in  1  one-cycle strobe, clear key
enter_stb  in  1  one-cycle strobe, enter key
charge_ack  in  1  back end accepted request
state  out  3  0 IDLE, 1 PHONE, 2 AMOUNT, 3 REQ, 4 DONE
phone_bcd  out  4*PHONE_LEN  entered digits, BCD, newest in [3:0]
phone_cnt  out  4  phone digits entered
amount  out  10  binary amount
amt_cnt  out  2  amount digits entered
charge_req  out  1  request level, held until ack
done  out  1  one-cycle pulse, transaction complete
err  out  1  one-cycle pulse, rejected enter
timeout  out  1  one-cycle pulse, inactivity abort

Behaviour:
- Reset, synchronous active-high on CLK: state=IDLE; phone_bcd, phone_cnt, amount, amt_cnt, idle counter all 0; charge_req, done, err, timeout all 0. RST asserted mid-transaction aborts it immediately with no pulses; charge_req drops the next edge.
- All outputs registered. Response appears on the edge that samples the strobe (1-cycle latency).
- Strobe priority within a cycle: clear > enter > digit. start_stb is ignored outside IDLE. Strobes are ignored in REQ and DONE.
- IDLE:
  - start_stb → PHONE; clears phone and amount fields.
  - All other inputs ignored.
- PHONE:
  - Valid digit with phone_cnt < PHONE_LEN: phone_bcd ← {phone_bcd shifted left 4, digit}; phone_cnt+1.
  - Digit when full is ignored (no err).
  - clear_stb with phone_cnt > 0: zero phone field. With phone_cnt = 0: → IDLE.
  - enter_stb with phone_cnt == PHONE_LEN: → AMOUNT. Otherwise: err pulse, stay, field kept.
- AMOUNT:
  - Valid digit with amt_cnt < AMT_DIGITS: amount ← amount*10 + digit (10-bit, no overflow possible within 3 digits); amt_cnt+1.
  - Leading zeros count as digits.
  - clear_stb with amt_cnt > 0: zero amount. With amt_cnt = 0: → PHONE, phone field retained.
  - enter_stb with 1 ≤ amount ≤ MAX_AMT: → REQ. Otherwise: err pulse, amount and amt_cnt zeroed, stay.
- REQ:
  - charge_req=1 from the entry edge.
  - charge_ack sampled high → charge_req=0, → DONE.
  - No timeout in REQ.
  - charge_ack outside REQ is ignored.
- DONE:
  - done=1 for exactly this one cycle, then → IDLE.
  - Phone and amount fields retained until the next start.
- Timeout:
  - A 24-bit idle counter runs in PHONE and AMOUNT only.
  - It resets to 0 on any accepted or ignored strobe, and on state entry.
  - Reaching TIMEOUT-1 → IDLE with a one-cycle timeout pulse; fields zeroed.
  - A strobe in the same cycle as expiry wins and the timeout does not fire.
- err, done, and timeout are never asserted simultaneously.

Test Plan:
- Reset then start, digits 1,3,8,0,0,1,3,8,0,0,0, enter → phone_cnt=11, phone_bcd=0x13800138000, state=AMOUNT one cycle after enter.
- In AMOUNT, digits 0,5,0, enter → amount=50, state=REQ, charge_req=1; charge_ack after 3 cycles → charge_req=0, done pulse exactly 1 cycle, state=IDLE.
- Enter after 10 phone digits → err pulse, phone_cnt stays 10. In AMOUNT, 9,9,9 then enter (MAX_AMT=500) → err, amount=0, amt_cnt=0. A 4th digit after 1,2,3 is ignored (amount=123).
- clear and digit strobes in the same cycle in PHONE with cnt=5 → field zeroed, cnt=0. Second clear → IDLE. Clear with amt_cnt=0 in AMOUNT → PHONE with phone_bcd intact.
- TIMEOUT=20 override: idle 19 cycles in AMOUNT → timeout pulse, state=IDLE, fields 0. A digit at cycle 18 restarts the count and no timeout occurs.
- RST asserted while charge_req=1 → next edge: charge_req=0, state=IDLE, no done pulse. A later charge_ack has no effect.
